// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : can_pkg
//  Purpose  : Shared definitions for the CAN TX scheduler: core register
//             select codes, status bit positions, byte-lane constants,
//             scheduler state encoding and the arbitration key helper.
//  Revision : 1.0  initial release
// ============================================================================
package can_pkg;

  // Core register select codes
  localparam logic [1:0] c_rs_id    = 2'd0;
  localparam logic [1:0] c_rs_dlc   = 2'd1;
  localparam logic [1:0] c_rs_data0 = 2'd2;
  localparam logic [1:0] c_rs_data1 = 2'd3;

  // Status bit positions in the rs=1 read word
  localparam int c_st_rts   = 8;
  localparam int c_st_lostf = 9;
  localparam int c_st_bitf  = 10;
  localparam int c_st_ackf  = 11;

  // Byte-lane patterns; the DLC lanes leave baud/irqen in the upper bytes alone
  localparam logic [3:0] c_bytesel_all = 4'b1111;
  localparam logic [3:0] c_bytesel_dlc = 4'b0011;
  localparam logic [3:0] c_bytesel_rd  = 4'b0000;

  localparam int c_key_w = 29;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_PICK   = 4'd1,
    ST_WR_ID  = 4'd2,
    ST_WR_D0  = 4'd3,
    ST_WR_D1  = 4'd4,
    ST_WR_DLC = 4'd5,
    ST_ARM    = 4'd6,
    ST_POLL   = 4'd7,
    ST_EVAL   = 4'd8
  } tx_state_e;

  // Standard IDs are left-aligned so they compare against extended IDs the way
  // the bus arbitrates them; the smaller key wins.
  function automatic logic [c_key_w-1:0] prio_key(input logic [31:0] id_word);
    return id_word[31] ? id_word[28:0] : {id_word[10:0], 18'h0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/can_prio_select.sv
`default_nettype none
// ============================================================================
//  Module   : can_prio_select
//  Purpose  : Combinational lowest-key finder over the pending mailboxes.
//             Ties resolve to the lower index.
//  Revision : 1.0  initial release
// ============================================================================
module can_prio_select
  import can_pkg::*;
#(
  parameter int NMB = 4,
  parameter int IW  = 2
) (
  input  logic [NMB-1:0][c_key_w-1:0] keys,
  input  logic [NMB-1:0]              pending,
  output logic                        valid,
  output logic [IW-1:0]               idx
);

  logic [c_key_w-1:0] w_best;

  // Linear scan; strict less-than keeps the earlier (lower) index on a tie
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    w_best = '1;
    for (int i = 0; i < NMB; i++) begin
      if (pending[i] && (!valid || (keys[i] < w_best))) begin
        valid  = 1'b1;
        idx    = IW'(i);
        w_best = keys[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/can_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : can_tx_scheduler
//  Purpose  : Multi-mailbox CAN transmit scheduler. Picks the lowest-key
//             pending mailbox, programs the single-frame core, polls status
//             and retries or reports per-mailbox done/fail.
//  Revision : 1.0  initial release
// ============================================================================
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int NMB       = 4,
  parameter int MAX_RETRY = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mb_wr,
  input  logic [2:0]     mb_sel,
  input  logic [1:0]     mb_word,
  input  logic [31:0]    mb_wdata,
  input  logic [NMB-1:0] mb_req,
  input  logic [NMB-1:0] mb_abort,
  output logic [NMB-1:0] mb_pending,
  output logic [NMB-1:0] mb_done,
  output logic [NMB-1:0] mb_fail,
  output logic           mb_wr_err,
  output logic           can_cs,
  output logic [1:0]     can_rs,
  output logic [3:0]     can_bytesel,
  output logic [31:0]    can_d,
  input  logic [31:0]    can_q,
  output logic           irq,
  input  logic           irq_ack
);

  localparam int IW = $clog2(NMB);

  tx_state_e state_q, state_d;

  logic [31:0]    id_q [NMB], id_d [NMB];
  logic [31:0]    d0_q [NMB], d0_d [NMB];
  logic [31:0]    d1_q [NMB], d1_d [NMB];
  logic [3:0]     dlc_q[NMB], dlc_d[NMB];

  logic [NMB-1:0] pending_q, pending_d;
  logic [IW-1:0]  act_q, act_d;
  logic [3:0]     retry_q, retry_d;
  logic [2:0]     status_q, status_d;   // {ackf, bitf, lostf}
  logic           arm_q, arm_d;
  logic           irq_q, irq_d;
  logic           wr_err_q, wr_err_d;

  logic [NMB-1:0][c_key_w-1:0] w_keys;
  logic                        w_valid;
  logic [IW-1:0]               w_idx;
  logic                        w_sel_ok;
  logic [IW-1:0]               w_sel;
  logic [NMB-1:0]              w_act_oh;
  logic [NMB-1:0]              w_abort_eff;
  logic                        w_success;
  logic                        w_exhausted;
  logic                        w_unused_q_bits;

  assign w_sel_ok        = ({29'd0, mb_sel} < 32'(NMB));
  assign w_sel           = mb_sel[IW-1:0];
  assign w_act_oh        = {{(NMB-1){1'b0}}, 1'b1} << act_q;
  assign w_success       = status_q[2] & ~status_q[0] & ~status_q[1];
  assign w_exhausted     = (retry_q == 4'(MAX_RETRY));
  assign w_unused_q_bits = ^{can_q[31:12], can_q[7:0]};

  // Arbitration keys for every mailbox
  always_comb begin
    for (int i = 0; i < NMB; i++) begin
      w_keys[i] = prio_key(id_q[i]);
    end
  end

  can_prio_select #(
    .NMB (NMB),
    .IW  (IW)
  ) u_prio (
    .keys    (w_keys),
    .pending (pending_q),
    .valid   (w_valid),
    .idx     (w_idx)
  );

  // Host writes land only in idle (non-pending) mailboxes; others flag an error
  always_comb begin
    id_d     = id_q;
    d0_d     = d0_q;
    d1_d     = d1_q;
    dlc_d    = dlc_q;
    wr_err_d = 1'b0;
    if (mb_wr && w_sel_ok) begin
      if (pending_q[w_sel]) begin
        wr_err_d = 1'b1;
      end else begin
        unique case (mb_word)
          2'd0: id_d[w_sel]  = mb_wdata;
          2'd1: dlc_d[w_sel] = mb_wdata[3:0];
          2'd2: d0_d[w_sel]  = mb_wdata;
          2'd3: d1_d[w_sel]  = mb_wdata;
          default: ;
        endcase
      end
    end
  end

  // Mailbox storage is deliberately not reset
  always_ff @(posedge clk) begin
    id_q  <= id_d;
    d0_q  <= d0_d;
    d1_q  <= d1_d;
    dlc_q <= dlc_d;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one core access per cycle through the frame sequence
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|pending_q) state_d = ST_PICK;
      ST_PICK:   state_d = w_valid ? ST_WR_ID : ST_IDLE;
      ST_WR_ID:  state_d = ST_WR_D0;
      ST_WR_D0:  state_d = ST_WR_D1;
      ST_WR_D1:  state_d = ST_WR_DLC;
      ST_WR_DLC: state_d = ST_ARM;
      ST_ARM:    if (arm_q) state_d = ST_POLL;
      ST_POLL:   if (!can_q[c_st_rts]) state_d = ST_EVAL;
      ST_EVAL:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: core bus master and per-mailbox result pulses
  always_comb begin
    can_cs      = 1'b0;
    can_rs      = c_rs_id;
    can_bytesel = c_bytesel_rd;
    can_d       = 32'h0;
    mb_done     = '0;
    mb_fail     = '0;
    unique case (state_q)
      ST_WR_ID: begin
        can_cs = 1'b1; can_rs = c_rs_id;    can_bytesel = c_bytesel_all; can_d = id_q[act_q];
      end
      ST_WR_D0: begin
        can_cs = 1'b1; can_rs = c_rs_data0; can_bytesel = c_bytesel_all; can_d = d0_q[act_q];
      end
      ST_WR_D1: begin
        can_cs = 1'b1; can_rs = c_rs_data1; can_bytesel = c_bytesel_all; can_d = d1_q[act_q];
      end
      ST_WR_DLC: begin
        can_cs = 1'b1; can_rs = c_rs_dlc;   can_bytesel = c_bytesel_dlc;
        can_d  = {23'h0, 1'b1, 4'h0, dlc_q[act_q]};
      end
      ST_POLL: begin
        can_cs = 1'b1; can_rs = c_rs_dlc;   can_bytesel = c_bytesel_rd;
      end
      ST_EVAL: begin
        if (w_success)        mb_done = w_act_oh;
        else if (w_exhausted) mb_fail = w_act_oh;
      end
      default: ;
    endcase
  end

  // Scheduler bookkeeping: pending bits, active index, retries, status, irq
  always_comb begin
    act_d    = act_q;
    retry_d  = retry_q;
    status_d = status_q;
    arm_d    = (state_q == ST_ARM) ? ~arm_q : 1'b0;

    // Abort of the mailbox on the wire is ignored once the core is being driven
    w_abort_eff = mb_abort;
    if (state_q != ST_IDLE && state_q != ST_PICK) w_abort_eff[act_q] = 1'b0;
    pending_d = (pending_q | mb_req) & ~w_abort_eff;

    if (state_q == ST_PICK && w_valid) begin
      act_d = w_idx;
      if (w_idx != act_q) retry_d = 4'd0;
    end
    if (state_q == ST_POLL && !can_q[c_st_rts]) begin
      status_d = can_q[c_st_ackf:c_st_lostf];
    end
    if (state_q == ST_EVAL) begin
      if (w_success || w_exhausted) begin
        pending_d[act_q] = 1'b0;
        retry_d          = 4'd0;
      end else begin
        retry_d = retry_q + 4'd1;
      end
    end

    if (|{mb_done, mb_fail}) irq_d = 1'b1;
    else if (irq_ack)        irq_d = 1'b0;
    else                     irq_d = irq_q;
  end

  // Bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      act_q     <= '0;
      retry_q   <= 4'd0;
      status_q  <= 3'd0;
      arm_q     <= 1'b0;
      irq_q     <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      act_q     <= act_d;
      retry_q   <= retry_d;
      status_q  <= status_d;
      arm_q     <= arm_d;
      irq_q     <= irq_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign mb_pending = pending_q;
  assign mb_wr_err  = wr_err_q;
  assign irq        = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_can_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_can_tx_scheduler
//  Purpose  : Self-checking bench for can_tx_scheduler with a behavioural
//             CAN core model whose outcome (ack / lost / no-ack) is settable.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_can_tx_scheduler;

  localparam int NMB = 4;
  localparam int MAX_RETRY = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mb_wr = 1'b0;
  logic [2:0]     mb_sel = '0;
  logic [1:0]     mb_word = '0;
  logic [31:0]    mb_wdata = '0;
  logic [NMB-1:0] mb_req = '0;
  logic [NMB-1:0] mb_abort = '0;
  logic [NMB-1:0] mb_pending, mb_done, mb_fail;
  logic           mb_wr_err, can_cs, irq;
  logic [1:0]     can_rs;
  logic [3:0]     can_bytesel;
  logic [31:0]    can_d, can_q;
  logic           irq_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  can_tx_scheduler #(.NMB(NMB), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n), .mb_wr(mb_wr), .mb_sel(mb_sel), .mb_word(mb_word),
    .mb_wdata(mb_wdata), .mb_req(mb_req), .mb_abort(mb_abort), .mb_pending(mb_pending),
    .mb_done(mb_done), .mb_fail(mb_fail), .mb_wr_err(mb_wr_err), .can_cs(can_cs),
    .can_rs(can_rs), .can_bytesel(can_bytesel), .can_d(can_d), .can_q(can_q),
    .irq(irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural CAN core model ----------------
  typedef struct { logic [31:0] id; logic [31:0] d0; logic [31:0] d1; logic [3:0] dlc; } frame_t;
  typedef struct { int cyc; logic [1:0] rs; logic [3:0] bs; logic [31:0] d; } wr_t;

  frame_t txlog[$];
  wr_t    wrlog[$];
  int     cyc = 0;
  logic [31:0] core_id = 0, core_d0 = 0, core_d1 = 0;
  logic   core_rts = 0, core_lost = 0, core_bit = 0, core_ack = 0;
  int     core_cnt = 0;
  int     lost_used = 0;
  int     lost_target = 0;
  bit     noack_mode = 0;
  int     illegal_rd = 0;
  int     done_cnt[NMB];
  int     fail_cnt[NMB];

  assign can_q = (can_cs && can_rs == 2'd1 && can_bytesel == 4'b0000)
               ? {20'h0, core_ack, core_bit, core_lost, core_rts, 8'h0} : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (can_cs && can_bytesel != 4'b0000) begin
      wrlog.push_back('{cyc, can_rs, can_bytesel, can_d});
      case (can_rs)
        2'd0: core_id <= can_d;
        2'd2: core_d0 <= can_d;
        2'd3: core_d1 <= can_d;
        default: if (can_d[8]) begin
          txlog.push_back('{core_id, core_d0, core_d1, can_d[3:0]});
          core_rts  <= 1'b1;
          core_cnt  <= 3 + int'($urandom_range(0, 3));
          core_lost <= 1'b0;
          core_bit  <= 1'b0;
          core_ack  <= 1'b0;
        end
      endcase
    end else if (core_rts) begin
      if (core_cnt <= 1) begin
        core_rts <= 1'b0;
        if (lost_used < lost_target) begin
          core_lost <= 1'b1;
          lost_used <= lost_used + 1;
        end else begin
          core_ack <= !noack_mode;
        end
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
    if (can_cs && can_rs == 2'd0 && can_bytesel == 4'b0000) illegal_rd <= illegal_rd + 1;
    for (int i = 0; i < NMB; i++) begin
      if (mb_done[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (mb_fail[i]) fail_cnt[i] <= fail_cnt[i] + 1;
    end
  end

  // ---------------- reference helpers ----------------
  function automatic logic [28:0] ref_key(input logic [31:0] w);
    if (w[31]) return w[28:0];
    return {w[10:0], 18'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mb(input int sel, input int word, input logic [31:0] data);
    mb_wr = 1'b1; mb_sel = 3'(sel); mb_word = 2'(word); mb_wdata = data;
    tick();
    mb_wr = 1'b0;
  endtask

  task automatic load_mb(input int sel, input frame_t f);
    write_mb(sel, 0, f.id);
    write_mb(sel, 1, {28'h0, f.dlc});
    write_mb(sel, 2, f.d0);
    write_mb(sel, 3, f.d1);
  endtask

  task automatic pulse_req(input logic [NMB-1:0] m);
    mb_req = m;
    tick();
    mb_req = '0;
  endtask

  task automatic wait_clear(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mb_pending == '0) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic ack_irq();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_checks++; if (can_cs !== 1'b0 || can_bytesel !== 4'h0 || can_d !== 32'h0 || can_rs !== 2'd0) begin
      n_fail++; $display("FAIL reset_core_port: cs=%b rs=%0d bs=%b d=%h, want all 0", can_cs, can_rs, can_bytesel, can_d); end
    n_checks++; if (mb_pending !== '0 || mb_done !== '0 || mb_fail !== '0) begin
      n_fail++; $display("FAIL reset_mb: pending=%b done=%b fail=%b, want 0", mb_pending, mb_done, mb_fail); end
    n_checks++; if (irq !== 1'b0 || mb_wr_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: irq=%b wr_err=%b, want 0", irq, mb_wr_err); end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (wrlog.size() != 0) begin
      n_fail++; $display("FAIL idle_no_access: %0d core writes, want 0", wrlog.size()); end
  endtask

  task automatic test_single();
    frame_t f; bit ok; int nw, nt, dc, fc;
    f = '{32'h0000_0123, 32'h1122_3344, 32'h5566_7788, 4'd8};
    nw = wrlog.size(); nt = txlog.size(); dc = done_cnt[0]; fc = fail_cnt[0];
    load_mb(0, f);
    pulse_req(4'b0001);
    wait_clear(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t1_timeout: pending=%b, want 0", mb_pending); end
    n_checks++; if (wrlog.size() - nw != 4) begin
      n_fail++; $display("FAIL t1_write_count: %0d, want 4", wrlog.size() - nw); end
    if (wrlog.size() - nw >= 4) begin
      n_checks++; if (wrlog[nw].rs !== 2'd0 || wrlog[nw].bs !== 4'hF || wrlog[nw].d !== f.id) begin
        n_fail++; $display("FAIL t1_wr_id: rs=%0d bs=%b d=%h, want 0 1111 %h", wrlog[nw].rs, wrlog[nw].bs, wrlog[nw].d, f.id); end
      n_checks++; if (wrlog[nw+1].rs !== 2'd2 || wrlog[nw+1].bs !== 4'hF || wrlog[nw+1].d !== f.d0) begin
        n_fail++; $display("FAIL t1_wr_d0: rs=%0d bs=%b d=%h, want 2 1111 %h", wrlog[nw+1].rs, wrlog[nw+1].bs, wrlog[nw+1].d, f.d0); end
      n_checks++; if (wrlog[nw+2].rs !== 2'd3 || wrlog[nw+2].bs !== 4'hF || wrlog[nw+2].d !== f.d1) begin
        n_fail++; $display("FAIL t1_wr_d1: rs=%0d bs=%b d=%h, want 3 1111 %h", wrlog[nw+2].rs, wrlog[nw+2].bs, wrlog[nw+2].d, f.d1); end
      n_checks++; if (wrlog[nw+3].rs !== 2'd1 || wrlog[nw+3].bs !== 4'b0011 || wrlog[nw+3].d !== 32'h0000_0108) begin
        n_fail++; $display("FAIL t1_wr_dlc: rs=%0d bs=%b d=%h, want 1 0011 00000108", wrlog[nw+3].rs, wrlog[nw+3].bs, wrlog[nw+3].d); end
      n_checks++; if (wrlog[nw+3].cyc - wrlog[nw].cyc != 3 || wrlog[nw+1].cyc - wrlog[nw].cyc != 1) begin
        n_fail++; $display("FAIL t1_consecutive: span=%0d, want 3", wrlog[nw+3].cyc - wrlog[nw].cyc); end
    end
    n_checks++; if (txlog.size() - nt != 1) begin
      n_fail++; $display("FAIL t1_tx_count: %0d, want 1", txlog.size() - nt); end
    n_checks++; if (done_cnt[0] - dc != 1 || fail_cnt[0] - fc != 0) begin
      n_fail++; $display("FAIL t1_done: done=%0d fail=%0d, want 1 0", done_cnt[0] - dc, fail_cnt[0] - fc); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL t1_irq_set: irq=%b, want 1", irq); end
    ack_irq();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL t1_irq_ack: irq=%b, want 0", irq); end
  endtask

  // Load all mailboxes, request a subset, check send order and frame contents
  task automatic run_batch(input frame_t f[NMB], input logic [NMB-1:0] mask, input string name);
    int exp_q[$]; int nt, tmp; bit ok;
    for (int i = 0; i < NMB; i++) if (mask[i]) exp_q.push_back(i);
    for (int a = 1; a < exp_q.size(); a++) begin
      for (int b = a; b > 0; b--) begin
        if (ref_key(f[exp_q[b]].id) < ref_key(f[exp_q[b-1]].id)) begin
          tmp = exp_q[b]; exp_q[b] = exp_q[b-1]; exp_q[b-1] = tmp;
        end
      end
    end
    for (int i = 0; i < NMB; i++) load_mb(i, f[i]);
    nt = txlog.size();
    pulse_req(mask);
    wait_clear(200 * NMB, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_timeout: pending=%b, want 0", name, mb_pending); end
    n_checks++; if (txlog.size() - nt != exp_q.size()) begin
      n_fail++; $display("FAIL %s_count: %0d frames, want %0d", name, txlog.size() - nt, exp_q.size()); end
    else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++; if (txlog[nt+k] != f[exp_q[k]]) begin
          n_fail++; $display("FAIL %s_frame%0d: id=%h d0=%h d1=%h dlc=%h, want mb%0d id=%h d0=%h d1=%h dlc=%h",
            name, k, txlog[nt+k].id, txlog[nt+k].d0, txlog[nt+k].d1, txlog[nt+k].dlc,
            exp_q[k], f[exp_q[k]].id, f[exp_q[k]].d0, f[exp_q[k]].d1, f[exp_q[k]].dlc); end
      end
    end
    ack_irq();
  endtask

  task automatic test_priority();
    frame_t f[NMB];
    f[0] = '{32'h0000_0200, 32'hA0A0_A0A0, 32'hB0B0_B0B0, 4'd1};
    f[1] = '{32'h0000_0100, 32'hA1A1_A1A1, 32'hB1B1_B1B1, 4'd2};
    f[2] = '{32'h8000_0001, 32'hA2A2_A2A2, 32'hB2B2_B2B2, 4'd3};
    f[3] = '{32'h0000_0000, 32'h0,         32'h0,         4'd0};
    run_batch(f, 4'b0111, "t2");
  endtask

  task automatic test_random();
    frame_t f[NMB]; logic [NMB-1:0] m; logic ext;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NMB; i++) begin
        ext = 1'($urandom_range(0, 1));
        f[i].id  = ext ? {1'b1, 1'($urandom_range(0, 1)), 1'b0, 11'($urandom_range(0, 3)), 18'h0}
                       : {1'b0, 1'($urandom_range(0, 1)), 19'h0, 11'($urandom_range(0, 5))};
        f[i].d0  = $urandom; f[i].d1 = $urandom; f[i].dlc = 4'($urandom_range(0, 8));
      end
      m = NMB'($urandom_range(1, (1 << NMB) - 1));
      run_batch(f, m, "rnd");
    end
  endtask

  task automatic test_lost_retry();
    frame_t f; bit ok; int nt, dc, fc;
    f = '{32'h0000_0055, 32'hCAFE_0001, 32'hCAFE_0002, 4'd4};
    nt = txlog.size(); dc = done_cnt[3]; fc = fail_cnt[3];
    lost_target = lost_used + 3;
    load_mb(3, f);
    pulse_req(4'b1000);
    wait_clear(400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t3_timeout: pending=%b, want 0", mb_pending); end
    n_checks++; if (txlog.size() - nt != 4) begin n_fail++; $display("FAIL t3_attempts: %0d, want 4", txlog.size() - nt); end
    n_checks++; if (done_cnt[3] - dc != 1 || fail_cnt[3] - fc != 0) begin
      n_fail++; $display("FAIL t3_result: done=%0d fail=%0d, want 1 0", done_cnt[3] - dc, fail_cnt[3] - fc); end
    ack_irq();
  endtask

  task automatic test_noack_fail();
    frame_t f; bit ok; int nt, dc, fc;
    f = '{32'h0000_0077, 32'h0BAD_0001, 32'h0BAD_0002, 4'd2};
    nt = txlog.size(); dc = done_cnt[1]; fc = fail_cnt[1];
    noack_mode = 1'b1;
    load_mb(1, f);
    pulse_req(4'b0010);
    wait_clear(1500, ok);
    noack_mode = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t4_timeout: pending=%b, want 0", mb_pending); end
    n_checks++; if (txlog.size() - nt != MAX_RETRY + 1) begin
      n_fail++; $display("FAIL t4_attempts: %0d, want %0d", txlog.size() - nt, MAX_RETRY + 1); end
    n_checks++; if (fail_cnt[1] - fc != 1 || done_cnt[1] - dc != 0) begin
      n_fail++; $display("FAIL t4_result: fail=%0d done=%0d, want 1 0", fail_cnt[1] - fc, done_cnt[1] - dc); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL t4_irq: irq=%b, want 1", irq); end
    ack_irq();
  endtask

  task automatic test_wr_err_abort();
    frame_t f; bit ok; int nt, nw;
    f = '{32'h0000_0111, 32'h1234_5678, 32'h9ABC_DEF0, 4'd6};
    load_mb(1, f);
    nt = txlog.size();
    pulse_req(4'b0010);
    write_mb(1, 0, 32'h0000_0222);
    n_checks++; if (mb_wr_err !== 1'b1) begin n_fail++; $display("FAIL t5_wr_err: %b, want 1", mb_wr_err); end
    tick();
    n_checks++; if (mb_wr_err !== 1'b0) begin n_fail++; $display("FAIL t5_wr_err_pulse: %b, want 0", mb_wr_err); end
    wait_clear(300, ok);
    n_checks++; if (!ok || txlog.size() - nt != 1 || txlog[txlog.size()-1].id !== f.id) begin
      n_fail++; $display("FAIL t5_contents: ok=%0d n=%0d id=%h, want 1 1 %h", ok, txlog.size() - nt,
        (txlog.size() > 0) ? txlog[txlog.size()-1].id : 32'h0, f.id); end
    ack_irq();
    nw = wrlog.size();
    mb_req = 4'b0010; mb_abort = 4'b0010;
    tick();
    mb_req = '0; mb_abort = '0;
    n_checks++; if (mb_pending !== '0) begin n_fail++; $display("FAIL t5_abort_wins: pending=%b, want 0", mb_pending); end
    repeat (20) tick();
    n_checks++; if (wrlog.size() != nw) begin n_fail++; $display("FAIL t5_abort_idle: %0d writes, want 0", wrlog.size() - nw); end
  endtask

  task automatic test_reset_in_poll();
    frame_t f; bit seen; int nw;
    f = '{32'h0000_0333, 32'h1, 32'h2, 4'd1};
    load_mb(0, f);
    pulse_req(4'b0001);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (can_cs && can_rs == 2'd1 && can_bytesel == 4'b0000) seen = 1'b1;
      else tick();
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL t6_poll_seen: 0, want 1"); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (can_cs !== 1'b0 || can_bytesel !== 4'h0 || can_d !== 32'h0 || mb_pending !== '0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL t6_async_reset: cs=%b bs=%b d=%h pend=%b irq=%b, want all 0", can_cs, can_bytesel, can_d, mb_pending, irq); end
    repeat (2) tick();
    rst_n = 1'b1;
    nw = wrlog.size();
    repeat (30) tick();
    n_checks++; if (wrlog.size() != nw || mb_pending !== '0) begin
      n_fail++; $display("FAIL t6_quiet_after: writes=%0d pend=%b, want 0 0", wrlog.size() - nw, mb_pending); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_lost_retry();
    test_noack_fail();
    test_wr_err_abort();
    test_random();
    test_reset_in_poll();
    n_checks++; if (illegal_rd != 0) begin n_fail++; $display("FAIL rs0_read: %0d, want 0", illegal_rd); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
